// File: rtl/lut_pkg.sv
// Shared types and helpers for the runtime-programmable truth-table gate.
// Provides the loader FSM state encoding, the beat-count helper and the
// largest supported input count.
package lut_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        COMMIT = 2'd2
    } lut_state_t;

    localparam int MAX_N_IN = 6;

    // Number of config beats needed to cover 2^n_in table rows.
    function automatic int lut_beats(input int n_in, input int cfg_w);
        return ((1 << n_in) + cfg_w - 1) / cfg_w;
    endfunction

endpackage

// File: rtl/lut_cfg_loader.sv
// Serial table loader: collects config beats into a shadow table, then commits it.
// Ports: cfg valid/ready/data/abort in; shadow_tbl and a one-cycle commit_pulse out.
// commit_pulse is high during the COMMIT cycle; cfg_ready is low only in COMMIT.
module lut_cfg_loader
    import lut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CFG_W-1:0]      cfg_data,
    input  logic                  cfg_abort,
    output logic                  commit_pulse,
    output logic [(1<<N_IN)-1:0]  shadow_tbl,
    output logic                  busy
);

    localparam int ROWS  = 1 << N_IN;
    localparam int BEATS = lut_beats(N_IN, CFG_W);
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    lut_state_t        state;
    logic [CNT_W-1:0]  beat_cnt;
    logic [ROWS-1:0]   shadow;
    logic              take;
    logic              wr;

    assign take       = cfg_valid && cfg_ready;
    // An abort in LOAD drops any beat presented alongside it.
    assign wr         = take && !(state == LOAD && cfg_abort);
    assign shadow_tbl = shadow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat_cnt     <= '0;
            shadow       <= '0;
            cfg_ready    <= 1'b1;
            busy         <= 1'b0;
            commit_pulse <= 1'b0;
        end else begin
            commit_pulse <= 1'b0;
            case (state)
                IDLE: begin
                    if (take) begin
                        busy <= 1'b1;
                        if (BEATS == 1) begin
                            state        <= COMMIT;
                            cfg_ready    <= 1'b0;
                            commit_pulse <= 1'b1;
                        end else begin
                            state    <= LOAD;
                            beat_cnt <= CNT_W'(1);
                        end
                    end
                end
                LOAD: begin
                    if (cfg_abort) begin
                        state    <= IDLE;
                        beat_cnt <= '0;
                        busy     <= 1'b0;
                    end else if (take) begin
                        if (int'(beat_cnt) == BEATS - 1) begin
                            state        <= COMMIT;
                            beat_cnt     <= '0;
                            cfg_ready    <= 1'b0;
                            commit_pulse <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    cfg_ready <= 1'b1;
                    busy      <= 1'b0;
                end
            endcase

            if (state == LOAD && cfg_abort) begin
                shadow <= '0;
            end else if (wr) begin
                // Row r lives in beat r/CFG_W at bit r%CFG_W; padding bits of
                // the last beat have no row and are never stored.
                for (int r = 0; r < ROWS; r++) begin
                    if (int'(beat_cnt) == r / CFG_W) begin
                        shadow[r] <= cfg_data[r % CFG_W];
                    end
                end
            end
        end
    end

endmodule

// File: rtl/truth_table_lut.sv
// Runtime-programmable N_IN-input truth-table gate with atomic table commit.
// Ports: cfg valid/ready load port, in_valid/in_vec request, out_valid/out result.
// Evaluation: 1-cycle latency, no backpressure; config stalls only in COMMIT.
module truth_table_lut
    import lut_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int CFG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CFG_W-1:0] cfg_data,
    input  logic             cfg_abort,
    input  logic             in_valid,
    input  logic [N_IN-1:0]  in_vec,
    output logic             out_valid,
    output logic             out,
    output logic             table_loaded,
    output logic             busy
);

    localparam int ROWS = 1 << N_IN;

    logic            commit_pulse;
    logic [ROWS-1:0] shadow_tbl;
    logic [ROWS-1:0] active_tbl;

    lut_cfg_loader #(
        .N_IN  (N_IN),
        .CFG_W (CFG_W)
    ) u_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_data     (cfg_data),
        .cfg_abort    (cfg_abort),
        .commit_pulse (commit_pulse),
        .shadow_tbl   (shadow_tbl),
        .busy         (busy)
    );

    // The active table swaps at the end of COMMIT, so a request issued during
    // COMMIT still sees the old contents.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_tbl   <= '0;
            table_loaded <= 1'b0;
            out          <= 1'b0;
            out_valid    <= 1'b0;
        end else begin
            if (commit_pulse) begin
                active_tbl   <= shadow_tbl;
                table_loaded <= 1'b1;
            end
            out_valid <= in_valid;
            if (in_valid) begin
                out <= active_tbl[in_vec];
            end
        end
    end

endmodule

// File: tb/tb_truth_table_lut.sv
module tb_truth_table_lut;

    localparam int R0 = 8;
    localparam int B0 = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: N_IN=3, CFG_W=4
    logic       rst_n, cfg_valid, cfg_ready, cfg_abort, in_valid;
    logic [3:0] cfg_data;
    logic [2:0] in_vec;
    logic       out_valid, out0, table_loaded, busy;

    // Instance 1: N_IN=1, CFG_W=4
    logic       rst_n1, cfg_valid1, cfg_ready1, cfg_abort1, in_valid1;
    logic [3:0] cfg_data1;
    logic [0:0] in_vec1;
    logic       out_valid1, out1, table_loaded1, busy1;

    truth_table_lut #(.N_IN(3), .CFG_W(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_data(cfg_data), .cfg_abort(cfg_abort), .in_valid(in_valid),
        .in_vec(in_vec), .out_valid(out_valid), .out(out0),
        .table_loaded(table_loaded), .busy(busy)
    );

    truth_table_lut #(.N_IN(1), .CFG_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n1), .cfg_valid(cfg_valid1), .cfg_ready(cfg_ready1),
        .cfg_data(cfg_data1), .cfg_abort(cfg_abort1), .in_valid(in_valid1),
        .in_vec(in_vec1), .out_valid(out_valid1), .out(out1),
        .table_loaded(table_loaded1), .busy(busy1)
    );

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboards: expected results pushed at issue, popped when out_valid shows.
    bit q0[$];
    bit q1[$];

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (q0.size() == 0) check("dut0_unexpected_out_valid", 1, 0);
            else check("dut0_out", int'(out0), int'(q0.pop_front()));
        end
        if (out_valid1 === 1'b1) begin
            if (q1.size() == 0) check("dut1_unexpected_out_valid", 1, 0);
            else check("dut1_out", int'(out1), int'(q1.pop_front()));
        end
    end

    // Reference model for instance 0, in terms of cycles and collected beats.
    int  cyc = 0;
    int  commit_at = -100;
    bit  mtbl[R0];
    bit  pend[R0];
    int  beats[$];
    bit  mloaded = 0;

    // One clock cycle for instance 0; called at posedge+1.
    task automatic cycle(input bit cv, input logic [3:0] d, input bit ab,
                         input bit iv, input logic [2:0] v);
        bit exp_ready, exp_busy;
        if (cyc == commit_at) begin
            for (int r = 0; r < R0; r++) mtbl[r] = pend[r];
            mloaded = 1;
        end
        exp_ready = (cyc != commit_at - 1);
        exp_busy  = (beats.size() > 0) || (cyc == commit_at - 1);
        check("cfg_ready", int'(cfg_ready), int'(exp_ready));
        check("busy", int'(busy), int'(exp_busy));
        check("table_loaded", int'(table_loaded), int'(mloaded));

        cfg_valid = cv; cfg_data = d; cfg_abort = ab; in_valid = iv; in_vec = v;
        if (iv) q0.push_back(mtbl[v]);
        if (cv && exp_ready) begin
            if (ab && beats.size() > 0) begin
                beats.delete();
            end else begin
                beats.push_back(int'(d));
                if (beats.size() == B0) begin
                    for (int r = 0; r < R0; r++) pend[r] = beats[r / 4][r % 4];
                    commit_at = cyc + 2;
                    beats.delete();
                end
            end
        end else if (ab && beats.size() > 0 && exp_ready) begin
            beats.delete();
        end
        @(posedge clk); #1;
        cyc++;
    endtask

    task automatic step1();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; cfg_valid = 0; cfg_data = '0; cfg_abort = 0; in_valid = 0; in_vec = '0;
        rst_n1 = 0; cfg_valid1 = 0; cfg_data1 = '0; cfg_abort1 = 0; in_valid1 = 0; in_vec1 = '0;
        #12;
        check("rst_out", int'(out0), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_table_loaded", int'(table_loaded), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_cfg_ready", int'(cfg_ready), 1);
        @(posedge clk); #1;
        rst_n = 1; rst_n1 = 1;
        @(posedge clk); #1;

        // Empty table: every row reads 0.
        for (int i = 0; i < 8; i++) cycle(0, 4'h0, 0, 1, 3'(i));
        // Load 8'hC0 and sweep (first sweep cycles still use the old table).
        cycle(1, 4'h0, 0, 0, 3'd0);
        cycle(1, 4'hC, 0, 0, 3'd0);
        for (int i = 0; i < 10; i++) cycle(0, 4'h0, 0, 1, 3'(i % 8));
        // Partial load then abort with a concurrent beat: table unchanged.
        cycle(1, 4'hF, 0, 1, 3'd0);
        cycle(1, 4'h3, 1, 1, 3'd6);
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 0, 1, 3'(i * 2));
        // Load 8'hEF while holding in_vec=5 through the commit.
        cycle(1, 4'hF, 0, 1, 3'd5);
        cycle(1, 4'hE, 0, 1, 3'd5);
        for (int i = 0; i < 4; i++) cycle(0, 4'h0, 0, 1, 3'd5);
        // Randomized traffic: toggling cfg_valid, occasional aborts.
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom % 2), 4'($urandom), ($urandom % 16) == 0,
                  ($urandom % 4) != 0, 3'($urandom));
        for (int i = 0; i < 3; i++) cycle(0, 4'h0, 0, 0, 3'd0);
        check("dut0_queue_drained", q0.size(), 0);

        // Instance 1: single-beat table with padding bits.
        cfg_valid1 = 1; cfg_data1 = 4'b1110;
        step1();
        cfg_valid1 = 0;
        check("dut1_busy_commit", int'(busy1), 1);
        check("dut1_ready_commit", int'(cfg_ready1), 0);
        step1();
        check("dut1_loaded", int'(table_loaded1), 1);
        in_valid1 = 1; in_vec1 = 1'b0; q1.push_back(1'b0);
        step1();
        in_vec1 = 1'b1; q1.push_back(1'b1);
        step1();
        in_valid1 = 0;
        step1();
        // Reset during a later commit clears everything.
        cfg_valid1 = 1; cfg_data1 = 4'b0011;
        step1();
        rst_n1 = 0; cfg_valid1 = 0;
        #1;
        check("dut1_rst_loaded", int'(table_loaded1), 0);
        check("dut1_rst_busy", int'(busy1), 0);
        check("dut1_rst_ready", int'(cfg_ready1), 1);
        check("dut1_rst_out", int'(out1), 0);
        step1();
        rst_n1 = 1;
        step1();
        in_valid1 = 1; in_vec1 = 1'b1; q1.push_back(1'b0);
        step1();
        in_vec1 = 1'b0; q1.push_back(1'b0);
        step1();
        in_valid1 = 0;
        step1();
        step1();
        check("dut1_loaded_after_rst", int'(table_loaded1), 0);
        check("dut1_queue_drained", q1.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
